// File: rtl/lcd_pkg.sv
// Shared command bytes, FSM state encoding and bus word type for lcd_panel_ctrl.
package lcd_pkg;

  localparam logic [7:0] CMD_DISPLAY_ON = 8'h3F;
  localparam logic [7:0] CMD_START_LINE = 8'hC0;
  localparam logic [7:0] CMD_SET_PAGE   = 8'hB8;
  localparam logic [7:0] CMD_SET_COL    = 8'h40;

  typedef enum logic [3:0] {
    ST_INIT_ON,
    ST_INIT_LINE,
    ST_CLR_PAGE,
    ST_CLR_COL,
    ST_CLR_DATA,
    ST_IDLE,
    ST_FR_PAGE,
    ST_FR_COL,
    ST_FR_DATA,
    ST_DONE
  } lcd_state_t;

  typedef struct packed {
    logic       di;
    logic [7:0] data;
  } lcd_bus_t;

  function automatic lcd_bus_t cmd_word(input logic [7:0] b);
    return '{di: 1'b0, data: b};
  endfunction

  function automatic lcd_bus_t data_word(input logic [7:0] b);
    return '{di: 1'b1, data: b};
  endfunction

endpackage

// File: rtl/lcd_bus_timer.sv
// Bus slot counter: 2*EN_DIV cycles per slot, strobe low in the first half.
// hold parks the counter at zero so a slot can wait for its data.
module lcd_bus_timer #(
  parameter int unsigned EN_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic hold,
  output logic slot_start,
  output logic slot_end,
  output logic LCD_en
);

  localparam int unsigned    CNT_W    = $clog2(2 * EN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * EN_DIV - 1);
  localparam logic [CNT_W-1:0] EN_ON    = CNT_W'(EN_DIV);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  assign slot_start = (cnt == '0);
  assign slot_end   = (cnt == CNT_LAST);

  always_comb begin
    cnt_nxt = cnt + CNT_W'(1);
    if (slot_end || (slot_start && hold)) cnt_nxt = '0;
  end

  // Strobe is registered from the next count so it tracks cnt >= EN_DIV exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      LCD_en <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      LCD_en <= (cnt_nxt >= EN_ON);
    end
  end

endmodule

// File: rtl/lcd_panel_ctrl.sv
// KS0108-class multi-chip LCD write controller: power-on, optional clear,
// then full-frame streaming from a valid/ready pixel source.
module lcd_panel_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned NUM_CS        = 2,
  parameter int unsigned PAGES         = 8,
  parameter int unsigned COLS          = 64,
  parameter int unsigned EN_DIV        = 4,
  parameter logic [7:0]  CLEAR_BYTE    = 8'h00,
  parameter bit          CLEAR_ON_INIT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic [7:0]        pix_data,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic              busy,
  output logic              frame_done,
  output logic              LCD_rst,
  output logic              LCD_rw,
  output logic [NUM_CS-1:0] LCD_cs,
  output logic              LCD_di,
  output logic              LCD_en,
  output logic [7:0]        LCD_data
);

  localparam int unsigned COL_W = $clog2(COLS);
  localparam int unsigned PG_W  = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam int unsigned CH_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COLS - 1);
  localparam logic [PG_W-1:0]  PAGE_LAST = PG_W'(PAGES - 1);
  localparam logic [CH_W-1:0]  CHIP_LAST = CH_W'(NUM_CS - 1);

  lcd_state_t        state;
  logic [COL_W-1:0]  col, col_nxt;
  logic [PG_W-1:0]   page, page_nxt;
  logic [CH_W-1:0]   chip, chip_nxt;
  lcd_bus_t          bus_q;
  logic [NUM_CS-1:0] cs_q;
  logic [NUM_CS-1:0] chip_oh;
  logic              col_last, page_last, chip_last, all_last;
  logic              slot_start, slot_end, hold;

  lcd_bus_timer #(.EN_DIV(EN_DIV)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .hold       (hold),
    .slot_start (slot_start),
    .slot_end   (slot_end),
    .LCD_en     (LCD_en)
  );

  assign LCD_rst  = ~rst;
  assign LCD_rw   = 1'b0;
  assign LCD_cs   = cs_q;
  assign LCD_di   = bus_q.di;
  assign LCD_data = bus_q.data;

  assign chip_oh   = NUM_CS'(1) << chip;
  assign col_last  = (col == COL_LAST);
  assign page_last = (page == PAGE_LAST);
  assign chip_last = (chip == CHIP_LAST);
  assign all_last  = col_last && page_last && chip_last;

  // Column/page/chip advance with explicit wrap at the last value.
  always_comb begin
    col_nxt  = col_last ? '0 : col + COL_W'(1);
    page_nxt = page;
    chip_nxt = chip;
    if (col_last) begin
      page_nxt = page_last ? '0 : page + PG_W'(1);
      if (page_last) chip_nxt = chip_last ? '0 : chip + CH_W'(1);
    end
  end

  // The slot counter waits at zero while idle and while a data slot has no byte yet.
  always_comb begin
    hold = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: hold = 1'b1;
      ST_FR_DATA:       hold = !(pix_valid && pix_ready);
      default:          hold = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_INIT_ON;
      col        <= '0;
      page       <= '0;
      chip       <= '0;
      bus_q      <= '0;
      cs_q       <= '0;
      pix_ready  <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b1;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_INIT_ON: begin
          if (slot_start) begin
            bus_q <= cmd_word(CMD_DISPLAY_ON);
            cs_q  <= '1;
          end
          if (slot_end) state <= ST_INIT_LINE;
        end
        ST_INIT_LINE: begin
          if (slot_start) begin
            bus_q <= cmd_word(CMD_START_LINE);
            cs_q  <= '1;
          end
          if (slot_end) begin
            if (CLEAR_ON_INIT) begin
              state <= ST_CLR_PAGE;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        ST_CLR_PAGE, ST_FR_PAGE: begin
          if (slot_start) begin
            bus_q <= cmd_word(CMD_SET_PAGE | 8'(page));
            cs_q  <= chip_oh;
          end
          if (slot_end) state <= (state == ST_CLR_PAGE) ? ST_CLR_COL : ST_FR_COL;
        end
        ST_CLR_COL, ST_FR_COL: begin
          if (slot_start) begin
            bus_q <= cmd_word(CMD_SET_COL);
            cs_q  <= chip_oh;
          end
          if (slot_end) begin
            if (state == ST_CLR_COL) begin
              state <= ST_CLR_DATA;
            end else begin
              state     <= ST_FR_DATA;
              pix_ready <= 1'b1;
            end
          end
        end
        ST_CLR_DATA: begin
          if (slot_start) begin
            bus_q <= data_word(CLEAR_BYTE);
            cs_q  <= chip_oh;
          end
          if (slot_end) begin
            col  <= col_nxt;
            page <= page_nxt;
            chip <= chip_nxt;
            if (all_last) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else if (col_last) begin
              state <= ST_CLR_PAGE;
            end
          end
        end
        ST_FR_DATA: begin
          if (pix_valid && pix_ready) begin
            bus_q     <= data_word(pix_data);
            cs_q      <= chip_oh;
            pix_ready <= 1'b0;
          end
          if (slot_end) begin
            col  <= col_nxt;
            page <= page_nxt;
            chip <= chip_nxt;
            if (all_last) begin
              state      <= ST_DONE;
              frame_done <= 1'b1;
            end else if (col_last) begin
              state <= ST_FR_PAGE;
            end else begin
              pix_ready <= 1'b1;
            end
          end
        end
        ST_IDLE: begin
          if (frame_start) begin
            state <= ST_FR_PAGE;
            busy  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_INIT_ON;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_panel_ctrl.sv
// Self-checking bench: default-parameter instance (init, ramp, stall) and a
// fast no-clear EN_DIV=1 instance (strobe timing, frame_start rules, reset).
module tb_lcd_panel_ctrl;

  typedef struct packed {
    logic [1:0] cs;
    logic       di;
    logic [7:0] data;
  } word_t;

  typedef struct {
    int         idx;
    logic [1:0] cs;
    logic       di;
    logic [7:0] data;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1, fs_a = 1'b0, pv_a = 1'b0;
  logic [7:0] pd_a = 8'h00;
  logic       pr_a, busy_a, fd_a, lrst_a, rw_a, di_a, en_a;
  logic [1:0] cs_a;
  logic [7:0] data_a;

  logic       rst_b = 1'b1, fs_b = 1'b0, pv_b = 1'b0;
  logic [7:0] pd_b = 8'h00;
  logic       pr_b, busy_b, fd_b, lrst_b, rw_b, di_b, en_b;
  logic [1:0] cs_b;
  logic [7:0] data_b;

  lcd_panel_ctrl dut_a (
    .clk(clk), .rst(rst_a), .frame_start(fs_a), .pix_data(pd_a), .pix_valid(pv_a),
    .pix_ready(pr_a), .busy(busy_a), .frame_done(fd_a), .LCD_rst(lrst_a), .LCD_rw(rw_a),
    .LCD_cs(cs_a), .LCD_di(di_a), .LCD_en(en_a), .LCD_data(data_a)
  );

  lcd_panel_ctrl #(.EN_DIV(1), .CLEAR_ON_INIT(1'b0)) dut_b (
    .clk(clk), .rst(rst_b), .frame_start(fs_b), .pix_data(pd_b), .pix_valid(pv_b),
    .pix_ready(pr_b), .busy(busy_b), .frame_done(fd_b), .LCD_rst(lrst_b), .LCD_rw(rw_b),
    .LCD_cs(cs_b), .LCD_di(di_b), .LCD_en(en_b), .LCD_data(data_b)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Panel-side monitors: record the bus word at every falling strobe edge.
  word_t mon_a[$];
  word_t mon_b[$];
  logic  pen_a = 1'b0, pen_b = 1'b0;
  word_t last_a, last_b;

  always @(negedge clk) begin
    if (rst_a) pen_a = 1'b0;
    else begin
      if (pen_a && !en_a) mon_a.push_back(last_a);
      pen_a  = en_a;
      last_a = {cs_a, di_a, data_a};
    end
    if (rst_b) pen_b = 1'b0;
    else begin
      if (pen_b && !en_b) mon_b.push_back(last_b);
      pen_b  = en_b;
      last_b = {cs_b, di_b, data_b};
    end
  end

  function automatic word_t wa(input int i);
    if (i < mon_a.size()) return mon_a[i];
    return '1;
  endfunction

  function automatic word_t wb(input int i);
    if (i < mon_b.size()) return mon_b[i];
    return '1;
  endfunction

  function automatic word_t mk(input vec_t v);
    return {v.cs, v.di, v.data};
  endfunction

  // Count data words on instance A and how many break the expected pattern.
  task automatic scan_a(input bit ramp, output int n_data, output int n_bad);
    n_data = 0;
    n_bad  = 0;
    foreach (mon_a[i]) begin
      if (mon_a[i].di) begin
        if (mon_a[i].data !== (ramp ? 8'(n_data) : 8'h00)) n_bad++;
        n_data++;
      end
    end
  endtask

  // One frame on instance A with ramp data; optional 10-cycle valid drop.
  task automatic frame_a(input int stall_at, output int cycles, output int fd_at,
                         output int fd_cnt, output int stall_bad);
    int sent, stall_left;
    bit stalled, acc;
    sent = 0; stall_left = 0; stalled = 0; stall_bad = 0;
    cycles = 0; fd_at = -1; fd_cnt = 0;
    @(negedge clk);
    fs_a = 1'b1; pv_a = 1'b1; pd_a = 8'h00;
    @(posedge clk);
    cycles = 1;
    @(negedge clk);
    fs_a = 1'b0;
    while (cycles < 20000) begin
      if (fd_a) begin
        fd_cnt++;
        if (fd_at < 0) fd_at = cycles;
      end
      if (!busy_a) break;
      if (stall_left == 0 && !stalled && stall_at >= 0 && sent == stall_at && pr_a) begin
        stalled = 1'b1;
        stall_left = 10;
      end
      if (stall_left > 0) begin
        pv_a = 1'b0;
        if (!pr_a || en_a) stall_bad++;
        stall_left--;
      end else begin
        pv_a = 1'b1;
      end
      acc = pv_a && pr_a;
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (acc) begin
        sent++;
        pd_a = 8'(sent);
      end
    end
  endtask

  vec_t init_tab[10];
  vec_t ramp_tab[9];

  initial begin
    int cyc, nd, nb, fd_at, fd_cnt, sbad, sent, guard, bcnt, prbad;
    bit acc;
    logic [3:0] en_pat;

    init_tab[0] = '{0,    2'b11, 1'b0, 8'h3F};
    init_tab[1] = '{1,    2'b11, 1'b0, 8'hC0};
    init_tab[2] = '{2,    2'b01, 1'b0, 8'hB8};
    init_tab[3] = '{3,    2'b01, 1'b0, 8'h40};
    init_tab[4] = '{4,    2'b01, 1'b1, 8'h00};
    init_tab[5] = '{68,   2'b01, 1'b0, 8'hB9};
    init_tab[6] = '{464,  2'b01, 1'b0, 8'hBF};
    init_tab[7] = '{530,  2'b10, 1'b0, 8'hB8};
    init_tab[8] = '{531,  2'b10, 1'b0, 8'h40};
    init_tab[9] = '{1057, 2'b10, 1'b1, 8'h00};

    ramp_tab[0] = '{0,    2'b01, 1'b0, 8'hB8};
    ramp_tab[1] = '{1,    2'b01, 1'b0, 8'h40};
    ramp_tab[2] = '{2,    2'b01, 1'b1, 8'h00};
    ramp_tab[3] = '{65,   2'b01, 1'b1, 8'h3F};
    ramp_tab[4] = '{66,   2'b01, 1'b0, 8'hB9};
    ramp_tab[5] = '{527,  2'b01, 1'b1, 8'hFF};
    ramp_tab[6] = '{528,  2'b10, 1'b0, 8'hB8};
    ramp_tab[7] = '{530,  2'b10, 1'b1, 8'h00};
    ramp_tab[8] = '{1055, 2'b10, 1'b1, 8'hFF};

    // Reset values on instance A.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_en", 32'(en_a), 0);
    chk("rst_data", 32'(data_a), 0);
    chk("rst_di_cs", 32'({di_a, cs_a}), 0);
    chk("rst_ready_done", 32'({pr_a, fd_a}), 0);
    chk("rst_busy", 32'(busy_a), 1);
    chk("rst_lcd_rst_rw", 32'({lrst_a, rw_a}), 0);

    // Init with clear, default parameters.
    @(negedge clk);
    rst_a = 1'b0;
    cyc = 0;
    while (cyc < 20000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (!busy_a) break;
    end
    chk("init_cycles", 32'(cyc), 8464);
    repeat (2) @(negedge clk);
    chk("init_words", 32'(mon_a.size()), 1058);
    for (int i = 0; i < 10; i++)
      chk($sformatf("init_word_%0d", init_tab[i].idx), 32'(wa(init_tab[i].idx)), 32'(mk(init_tab[i])));
    scan_a(1'b0, nd, nb);
    chk("init_clear_count", 32'(nd), 1024);
    chk("init_clear_value", 32'(nb), 0);
    chk("idle_outputs", 32'({pr_a, lrst_a, rw_a}), 32'b010);

    // Ramp frame, no stalls.
    mon_a.delete();
    frame_a(-1, cyc, fd_at, fd_cnt, sbad);
    chk("ramp_frame_cycles", 32'(cyc), 8450);
    chk("ramp_done_at", 32'(fd_at), 8449);
    chk("ramp_done_pulses", 32'(fd_cnt), 1);
    repeat (2) @(negedge clk);
    chk("ramp_words", 32'(mon_a.size()), 1056);
    for (int i = 0; i < 9; i++)
      chk($sformatf("ramp_word_%0d", ramp_tab[i].idx), 32'(wa(ramp_tab[i].idx)), 32'(mk(ramp_tab[i])));
    scan_a(1'b1, nd, nb);
    chk("ramp_bytes", 32'(nd), 1024);
    chk("ramp_values", 32'(nb), 0);

    // Ramp frame with a 10-cycle valid drop at column 30.
    mon_a.delete();
    frame_a(30, cyc, fd_at, fd_cnt, sbad);
    chk("stall_frame_cycles", 32'(cyc), 8460);
    chk("stall_en_ready", 32'(sbad), 0);
    repeat (2) @(negedge clk);
    scan_a(1'b1, nd, nb);
    chk("stall_bytes", 32'(nd), 1024);
    chk("stall_values", 32'(nb), 0);

    // Instance B: two-slot init, strobe toggles, frame_start held during init.
    @(negedge clk);
    rst_b = 1'b0;
    fs_b  = 1'b1;
    pv_b  = 1'b1;
    cyc = 0;
    en_pat = '0;
    while (cyc < 100) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc <= 4) en_pat[4-cyc] = en_b;
      if (!busy_b) break;
    end
    fs_b = 1'b0;
    chk("b_init_cycles", 32'(cyc), 4);
    chk("b_en_toggle", 32'(en_pat), 32'b1010);
    bcnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy_b) bcnt++;
    end
    chk("b_init_fs_ignored", 32'(bcnt), 0);
    chk("b_init_words", 32'(mon_b.size()), 2);
    chk("b_init_on", 32'(wb(0)), 32'({2'b11, 1'b0, 8'h3F}));
    chk("b_init_line", 32'(wb(1)), 32'({2'b11, 1'b0, 8'hC0}));

    // Instance B frame with a mid-frame frame_start pulse.
    sent = 0;
    pd_b = 8'h00;
    fs_b = 1'b1;
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    fs_b = 1'b0;
    while (cyc < 5000 && !fd_b) begin
      fs_b = (cyc == 50);
      acc = pv_b && pr_b;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (acc) begin
        sent++;
        pd_b = 8'(sent);
      end
    end
    chk("b_frame_done_at", 32'(cyc), 2113);
    chk("b_frame_bytes", 32'(sent), 1024);

    // Pulse in the DONE cycle is ignored; held into the first IDLE cycle it starts.
    fs_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("b_done_fs_ignored", 32'(busy_b), 0);
    chk("b_done_single_cycle", 32'(fd_b), 0);
    sent = 0;
    pd_b = 8'h00;
    @(posedge clk);
    @(negedge clk);
    fs_b = 1'b0;
    chk("b_idle_fs_starts", 32'(busy_b), 1);

    // Reset in the middle of the new frame.
    guard = 0;
    while (sent < 30 && guard < 2000) begin
      acc = pv_b && pr_b;
      @(posedge clk);
      guard++;
      @(negedge clk);
      if (acc) begin
        sent++;
        pd_b = 8'(sent);
      end
    end
    chk("b_reached_col30", 32'(sent), 30);
    rst_b = 1'b1;
    #1;
    chk("b_rst_en_data", 32'({en_b, data_b}), 0);
    chk("b_rst_di_cs", 32'({di_b, cs_b}), 0);
    chk("b_rst_ready_done", 32'({pr_b, fd_b}), 0);
    chk("b_rst_busy_lcdrst", 32'({busy_b, lrst_b}), 32'b10);
    mon_b.delete();
    @(negedge clk);
    rst_b = 1'b0;
    cyc = 0;
    prbad = 0;
    while (cyc < 100) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (pr_b) prbad++;
      if (!busy_b) break;
    end
    chk("b_reinit_cycles", 32'(cyc), 4);
    chk("b_reinit_no_ready", 32'(prbad), 0);
    repeat (2) @(negedge clk);
    chk("b_reinit_words", 32'(mon_b.size()), 2);
    chk("b_reinit_on", 32'(wb(0)), 32'({2'b11, 1'b0, 8'h3F}));
    chk("b_reinit_line", 32'(wb(1)), 32'({2'b11, 1'b0, 8'hC0}));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lcd_panel_ctrl.md
# lcd_panel_ctrl

Parametrised write-only controller for KS0108-class segmented graphic LCDs: NUM_CS controller chips, each PAGES×COLS bytes. After reset it powers the panel on and fills every byte with CLEAR_BYTE. It then streams full frames from an upstream pixel source over a valid/ready handshake, issuing page/column address commands per page. It sits between the frame-buffer reader and the panel pins and replaces the single-half, fixed-timing controller.

## Interface
- NUM_CS, 2, number of controller chips (≥1)
- PAGES, 8, pages per chip (≥1)
- COLS, 64, columns per page (≥2, ≤64)
- EN_DIV, 4, clk cycles per LCD_en half-period (≥1)
- CLEAR_BYTE, 8'h00, fill value written at init
- CLEAR_ON_INIT, 1, 0 skips the clear pass
- clk  in  1  system clock
- rst  in  1  reset; one clock, asynchronous, active-high
- frame_start  in  1  request one full-frame transfer; sampled only in IDLE
- pix_data  in  8  display byte (bit0 = top row of page)
- pix_valid  in  1  pix_data valid
- pix_ready  out  1  controller accepts pix_data this cycle
- busy  out  1  high except in IDLE
- frame_done  out  1  one-cycle pulse after the last frame byte is strobed
- LCD_rst  out  1  panel reset, = ~rst (combinational)
- LCD_rw  out  1  constant 0
- LCD_cs  out  NUM_CS  chip selects, active-high
- LCD_di  out  1  0 = command, 1 = data
- LCD_en  out  1  write strobe; panel latches on falling edge
- LCD_data  out  8  panel bus

## Operation
- Bus slot: counter cnt 0..2·EN_DIV−1. LCD_data/LCD_di/LCD_cs load at cnt==0. LCD_en=0 for cnt<EN_DIV, 1 otherwise. Slot ends at wrap; the falling edge commits the byte.
- States: INIT_ON → INIT_LINE → (CLR_PAGE → CLR_COL → CLR_DATA)* → IDLE → (FR_PAGE → FR_COL → FR_DATA)* → DONE → IDLE.
- INIT_ON: 8'h3F. INIT_LINE: 8'hC0. Both have di=0 and all LCD_cs high.
- PAGE: 8'hB8|page. COL: 8'h40. Both di=0 and one-hot LCD_cs on the current chip.
- CLR_DATA: CLEAR_BYTE, di=1, COLS slots.
- FR_DATA: pix_data, di=1, COLS slots. The panel auto-increments the column.
- Order: chip 0 page 0..PAGES−1, then chip 1, and so on. col/page/chip counters wrap to 0 after the last value.
- When CLEAR_ON_INIT=0, INIT_LINE goes directly to IDLE.
- FR_DATA stall: at cnt==0, pix_ready=1 and cnt is held at 0 with LCD_en=0 until pix_valid&&pix_ready. That cycle loads LCD_data. pix_ready=0 for the rest of the slot.
- Only one byte is accepted per slot. No buffering.
- frame_start outside IDLE is ignored, with no queuing.
- A frame_start in the same cycle as the DONE→IDLE transition is ignored; the first accepting cycle is the first IDLE cycle.
- Width rules: col counter $clog2(COLS), page counter $clog2(PAGES), chip counter max(1,$clog2(NUM_CS)). Use wrap compare against parameter−1, never natural overflow.
- Reset mid-operation: all state returns to reset values. The init and clear sequence restarts, and no partial frame resumes.

## Timing
- Reset values: LCD_en=0, LCD_data=0, LCD_di=0, LCD_cs=0, pix_ready=0, frame_done=0, busy=1, state=INIT_ON, cnt=0.
- First slot begins on the first clk edge after rst deasserts.
- Init duration in slots: 2 + CLEAR_ON_INIT·NUM_CS·PAGES·(COLS+2). Multiply by 2·EN_DIV cycles; defaults give 1058 slots = 8464 cycles until busy falls.
- frame_start in IDLE sets busy=1 on the next cycle, and the FR_PAGE slot starts that cycle.
- Frame without stalls: NUM_CS·PAGES·(COLS+2)·2·EN_DIV cycles. Each stall cycle adds exactly one cycle.
- frame_done is high for the single cycle after the final FR_DATA slot wraps (the DONE state). The next cycle is IDLE with busy=0.

## Structure
- Package lcd_pkg holds:
  - command constants CMD_DISPLAY_ON=8'h3F, CMD_START_LINE=8'hC0, CMD_SET_PAGE=8'hB8, CMD_SET_COL=8'h40;
  - the state enum lcd_state_t.
- Sub-module lcd_bus_timer holds the slot counter. It outputs slot_start, LCD_en and slot_end, and takes a hold input used for the FR_DATA stall.
- The top level contains the FSM, counters and output registers.

## Test plan
- Reset release with defaults → bus shows 8'h3F and 8'hC0 with cs=2'b11, then per chip/page B8+p, 40 and 64×00. busy falls after exactly 8464 cycles.
- CLEAR_ON_INIT=0, EN_DIV=1 → two slots, then busy=0 at cycle 4, and LCD_en toggles every cycle.
- frame_start with pix_valid held high and ramp data 0..1023 mod 256 → chip 0 page 0 gets bytes 0..63 with cs=01. Chip 1 page 7 gets the final byte 8'hFF with cs=10. frame_done pulses once.
- pix_valid low for 10 cycles mid-page → LCD_en stays 0, pix_ready stays 1 and no byte is lost. Frame length grows by exactly 10 cycles.
- frame_start during init and during a frame → ignored. A pulse in the DONE cycle is ignored, and a pulse in the next cycle starts a frame.
- rst asserted mid-frame at column 30 → outputs reach reset values immediately. After release, the 8'h3F init sequence restarts and pix_ready stays 0 until IDLE.
